gate_bist_checker: RTL and testbench
====================================

// Module: gate_bist_checker
// PURPOSE
//  On-chip stimulus/response engine for the two-input basic-gate block; the consuming end of its truth-table interface.
//  Drives a/b through all four input vectors, waits for settling, samples the seven gate outputs and compares them to a golden table.
//  Reports pass/fail, a saturating error count and the first failing vector and bit mask.
//  Sits beside the gate block in synthesised builds as a self-test; no simulator needed.
// PARAMETERS
//  SETTLE_CYCLES  4  clocks between a vector change and the sample; legal range 1..255
//  PASSES         2  full sweeps of vectors 00,10,01,11 per run; legal range 1..15
//  ERR_W          8  width of err_count; saturates at all-ones
// PORTS
//  clk             in   1      single clock, rising edge
//  rst_n           in   1      asynchronous, active-low reset
//  start           in   1      1-cycle pulse; honoured only in IDLE or DONE
//  abort           in   1      level; forces IDLE on next edge, results keep current values
//  gate_in         in   7      {and,or,nand,not,nor,xor,xnor} from gate block
//  a_out           out  1      drives gate block input a
//  b_out           out  1      drives gate block input b
//  busy            out  1      high in DRIVE/SETTLE/CHECK
//  done            out  1      high in DONE until next start or abort
//  pass            out  1      valid when done; 1 = zero mismatches
//  err_count       out  ERR_W  number of mismatching samples (vector-level, not bit-level)
//  first_err_vec   out  2      {a,b} of first mismatch; 0 if none
//  first_err_mask  out  7      gate_in XOR expected at first mismatch; 0 if none
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, vector index 0, pass counter 0.
//  Golden (a,b): and=a&b, or=a|b, nand=~(a&b), not=~a, nor=~(a|b), xor=a^b, xnor=~(a^b).
//  Vector order per pass: (1,0)? no -- fixed order idx0 (0,0), idx1 (1,0), idx2 (0,1), idx3 (1,1).
//  FSM: IDLE -start-> DRIVE; DRIVE (1 clk: register a_out/b_out, load settle ctr) -> SETTLE;
//   SETTLE counts SETTLE_CYCLES clocks -> CHECK; CHECK (1 clk: compare, update results) ->
//   DRIVE with next vector, or DONE after idx3 of final pass; DONE -start-> DRIVE (new run).
//  start in DRIVE/SETTLE/CHECK ignored. On accepted start: err_count, first_err_*, pass, done cleared same edge.
//  Sample taken from gate_in registered in CHECK; latency start->first sample = 2+SETTLE_CYCLES clocks.
//  Run length = PASSES*4*(SETTLE_CYCLES+2) clocks from start edge to done rising.
//  Mismatch: err_count += 1 unless all-ones (saturate, no wrap); first_err_* written only when err_count was 0.
//  pass = (err_count==0) computed at entry to DONE; 0 otherwise.
//  abort has priority over start and state logic; a_out/b_out return to 0 on abort; done stays 0.
//  Simultaneous start+abort: abort wins, stays IDLE.
//  Reset mid-run: immediate return to reset values, no partial result retained.
//  a_out/b_out change only on DRIVE edges; held stable through SETTLE and CHECK.
// STRUCTURE
//  Shared package gate_bist_pkg: state enum (IDLE,DRIVE,SETTLE,CHECK,DONE), gate bit-index constants, golden-function returning 7-bit expected for {a,b}.
//  One sub-module: gate_bist_golden (combinational {a,b} -> 7-bit expected), reused by the bench scoreboard.
//  Top holds FSM, settle counter, vector/pass counters, result registers.
// TESTING
//  T1 Reset: rst_n low mid-SETTLE -> all outputs 0 within same cycle, IDLE after release.
//  T2 Good DUT (real gate block), defaults: start -> done after 2*4*6=48 clks, pass=1, err_count=0, first_err_*=0.
//  T3 Stuck-at xor=0 model: start -> err_count=4 (2 passes x vectors 10,01), first_err_vec=2'b10, first_err_mask=7'b0000010, pass=0.
//  T4 Saturation, ERR_W=2, all outputs inverted: err_count=3 after 8 mismatches, first_err_vec=00, mask=7'h7F.
//  T5 abort at clk 10 of run, start same cycle -> IDLE, busy=0, done=0, a_out=b_out=0; restart runs full 48 clks.
//  T6 start pulsed during SETTLE -> ignored, run length unchanged; start in DONE -> results cleared, new run begins.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// Shared types and helpers for the two-input gate self-test engine.
//   state_e       : checker FSM states
//   BIT_*         : bit positions in the 7-bit gate vector {and,or,nand,not,nor,xor,xnor}
//   golden_gates  : expected 7-bit gate response for inputs a, b
package gate_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_e;

  localparam int GATE_W   = 7;
  localparam int BIT_AND  = 6;
  localparam int BIT_OR   = 5;
  localparam int BIT_NAND = 4;
  localparam int BIT_NOT  = 3;
  localparam int BIT_NOR  = 2;
  localparam int BIT_XOR  = 1;
  localparam int BIT_XNOR = 0;

  function automatic logic [GATE_W-1:0] golden_gates(input logic a, input logic b);
    logic [GATE_W-1:0] g;
    g           = '0;
    g[BIT_AND]  = a & b;
    g[BIT_OR]   = a | b;
    g[BIT_NAND] = ~(a & b);
    g[BIT_NOT]  = ~a;
    g[BIT_NOR]  = ~(a | b);
    g[BIT_XOR]  = a ^ b;
    g[BIT_XNOR] = ~(a ^ b);
    return g;
  endfunction

endpackage

// File: rtl/gate_bist_checker_if.sv
// Control, status and gate-stimulus bundle of the gate self-test engine.
//   start/abort        : run control from the controller
//   gate_in            : {and,or,nand,not,nor,xor,xnor} returned by the gate block
//   a_out/b_out        : stimulus to the gate block
//   busy/done/pass     : run status
//   err_count          : saturating count of mismatching vectors
//   first_err_vec/mask : {a,b} and XOR mask of the first mismatch
// master = controller + gate block side, slave = checker.
interface gate_bist_checker_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic             abort;
  logic [6:0]       gate_in;
  logic             a_out;
  logic             b_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       first_err_vec;
  logic [6:0]       first_err_mask;

  modport master (
    output start, abort, gate_in,
    input  a_out, b_out, busy, done, pass, err_count, first_err_vec, first_err_mask
  );

  modport slave (
    input  start, abort, gate_in,
    output a_out, b_out, busy, done, pass, err_count, first_err_vec, first_err_mask
  );
endinterface

// File: rtl/gate_bist_golden.sv
// Combinational golden response of the two-input gate block.
//   a, b     : applied stimulus
//   expected : {and,or,nand,not,nor,xor,xnor} a fault-free block must return
module gate_bist_golden
  import gate_bist_pkg::*;
(
  input  logic              a,
  input  logic              b,
  output logic [GATE_W-1:0] expected
);

  assign expected = golden_gates(a, b);

endmodule

// File: rtl/gate_bist_checker.sv
// Stimulus/response self-test engine for the two-input gate block.
// Sweeps {a,b} through idx0 (0,0), idx1 (1,0), idx2 (0,1), idx3 (1,1) for PASSES
// sweeps, waits SETTLE_CYCLES after each vector change, compares gate_in with the
// golden table and records a saturating error count plus the first failure.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : control/status/stimulus bundle (slave side)
//
// state  | meaning
// IDLE   | waiting for start, stimulus parked at 0
// DRIVE  | register next vector on a/b, load settle timer
// SETTLE | settle timer counting down to terminal count
// CHECK  | compare gate_in with golden, update results, advance vector/pass
// DONE   | results valid, waiting for start
module gate_bist_checker
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int PASSES        = 2,
  parameter int ERR_W         = 8
) (
  input logic               clk,
  input logic               rst_n,
  gate_bist_checker_if.slave bus
);

  state_e            state_q, state_d;
  logic [7:0]        settle_q, settle_d;
  logic [1:0]        vec_idx_q, vec_idx_d;
  logic [3:0]        pass_cnt_q, pass_cnt_d;
  logic              a_q, a_d, b_q, b_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [1:0]        first_vec_q, first_vec_d;
  logic [GATE_W-1:0] first_mask_q, first_mask_d;
  logic              pass_q, pass_d;

  logic [GATE_W-1:0] expected;
  logic [GATE_W-1:0] diff;
  logic              last_vec;

  gate_bist_golden u_golden (
    .a        (a_q),
    .b        (b_q),
    .expected (expected)
  );

  // a_q/b_q are held from DRIVE through CHECK, so the golden value matches the sample
  assign diff     = bus.gate_in ^ expected;
  assign last_vec = (vec_idx_q == 2'd3) && (pass_cnt_q == 4'(PASSES - 1));

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    vec_idx_d    = vec_idx_q;
    pass_cnt_d   = pass_cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    err_d        = err_q;
    first_vec_d  = first_vec_q;
    first_mask_d = first_mask_q;
    pass_d       = pass_q;

    if (bus.abort) begin
      // results are left as they are; only the sequencing is parked
      state_d    = IDLE;
      settle_d   = '0;
      vec_idx_d  = '0;
      pass_cnt_d = '0;
      a_d        = 1'b0;
      b_d        = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_d      = DRIVE;
            vec_idx_d    = '0;
            pass_cnt_d   = '0;
            err_d        = '0;
            first_vec_d  = '0;
            first_mask_d = '0;
            pass_d       = 1'b0;
          end
        end
        DRIVE: begin
          a_d      = vec_idx_q[0];
          b_d      = vec_idx_q[1];
          settle_d = 8'(SETTLE_CYCLES);
          state_d  = SETTLE;
        end
        SETTLE: begin
          settle_d = settle_q - 8'd1;
          if (settle_q == 8'd1) state_d = CHECK;
        end
        CHECK: begin
          if (|diff) begin
            if (err_q != '1) err_d = err_q + ERR_W'(1);
            if (err_q == '0) begin
              first_vec_d  = {a_q, b_q};
              first_mask_d = diff;
            end
          end
          if (last_vec) begin
            state_d = DONE;
            pass_d  = (err_d == '0);
          end else begin
            state_d   = DRIVE;
            vec_idx_d = vec_idx_q + 2'd1;
            if (vec_idx_q == 2'd3) pass_cnt_d = pass_cnt_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      settle_q     <= '0;
      vec_idx_q    <= '0;
      pass_cnt_q   <= '0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      err_q        <= '0;
      first_vec_q  <= '0;
      first_mask_q <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      vec_idx_q    <= vec_idx_d;
      pass_cnt_q   <= pass_cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      err_q        <= err_d;
      first_vec_q  <= first_vec_d;
      first_mask_q <= first_mask_d;
      pass_q       <= pass_d;
    end
  end

  assign bus.a_out          = a_q;
  assign bus.b_out          = b_q;
  assign bus.busy           = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == CHECK);
  assign bus.done           = (state_q == DONE);
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.first_err_vec  = first_vec_q;
  assign bus.first_err_mask = first_mask_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
module tb_gate_bist_checker;

  localparam int S   = 4;
  localparam int P   = 2;
  localparam int RUN = P * 4 * (S + 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // per-vector fault injected on top of an ideal gate block, indexed a + 2*b
  logic [6:0] flip [4];

  gate_bist_checker_if #(.ERR_W(8)) bus8 ();
  gate_bist_checker_if #(.ERR_W(2)) bus2 ();

  gate_bist_checker #(.SETTLE_CYCLES(S), .PASSES(P), .ERR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  gate_bist_checker #(.SETTLE_CYCLES(S), .PASSES(P), .ERR_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  function automatic logic [6:0] ref_gates(input logic a, input logic b);
    return {a & b, a | b, ~(a & b), ~a, ~(a | b), a ^ b, ~(a ^ b)};
  endfunction

  assign bus8.gate_in = ref_gates(bus8.a_out, bus8.b_out) ^ flip[{bus8.b_out, bus8.a_out}];
  assign bus2.gate_in = ref_gates(bus2.a_out, bus2.b_out) ^ flip[{bus2.b_out, bus2.a_out}];
  assign bus2.start   = bus8.start;
  assign bus2.abort   = bus8.abort;

  // expected results of one complete run
  int         m_err8, m_err2, m_first_cyc;
  logic [1:0] m_vec;
  logic [6:0] m_mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_run();
    logic [1:0] iv;
    m_err8 = 0; m_err2 = 0; m_vec = 2'b00; m_mask = 7'h00; m_first_cyc = -1;
    for (int p = 0; p < P; p++) begin
      for (int i = 0; i < 4; i++) begin
        if (flip[i] != 7'h00) begin
          if (m_err8 == 0) begin
            iv          = 2'(i);
            m_vec       = {iv[0], iv[1]};
            m_mask      = flip[i];
            m_first_cyc = (p * 4 + i + 1) * (S + 2);
          end
          if (m_err8 < 255) m_err8++;
          if (m_err2 < 3) m_err2++;
        end
      end
    end
  endtask

  // Call at #1 after a rising edge with the DUT in IDLE or DONE.
  // glitch_cyc >= 0 pulses start once more while the run is in progress.
  task automatic run_check(input string tag, input int glitch_cyc);
    int cyc;
    int first_cyc;
    model_run();
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    chk({tag, ".clr_busy"}, 32'(bus8.busy), 32'd1);
    chk({tag, ".clr_done"}, 32'(bus8.done), 32'd0);
    chk({tag, ".clr_err"}, 32'(bus8.err_count), 32'd0);
    chk({tag, ".clr_vec"}, 32'(bus8.first_err_vec), 32'd0);
    chk({tag, ".clr_mask"}, 32'(bus8.first_err_mask), 32'd0);
    chk({tag, ".clr_pass"}, 32'(bus8.pass), 32'd0);
    cyc = 0;
    first_cyc = -1;
    while (bus8.done !== 1'b1 && cyc < RUN + 20) begin
      @(posedge clk); #1;
      cyc++;
      bus8.start = (cyc == glitch_cyc);
      if (first_cyc < 0 && bus8.err_count != 8'd0) first_cyc = cyc;
    end
    bus8.start = 1'b0;
    chk({tag, ".len"}, 32'(cyc), 32'(RUN));
    chk({tag, ".busy_end"}, 32'(bus8.busy), 32'd0);
    chk({tag, ".err8"}, 32'(bus8.err_count), 32'(m_err8));
    chk({tag, ".err2"}, 32'(bus2.err_count), 32'(m_err2));
    chk({tag, ".vec"}, 32'(bus8.first_err_vec), 32'(m_vec));
    chk({tag, ".mask"}, 32'(bus8.first_err_mask), 32'(m_mask));
    chk({tag, ".pass"}, 32'(bus8.pass), 32'(m_err8 == 0));
    chk({tag, ".first_cyc"}, 32'(first_cyc), 32'(m_first_cyc));
  endtask

  task automatic set_flips(input logic [6:0] f0, input logic [6:0] f1,
                           input logic [6:0] f2, input logic [6:0] f3);
    flip[0] = f0; flip[1] = f1; flip[2] = f2; flip[3] = f3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus8.start = 1'b0;
    bus8.abort = 1'b0;
    set_flips(7'h00, 7'h00, 7'h00, 7'h00);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.a", 32'(bus8.a_out), 32'd0);
    chk("rst.b", 32'(bus8.b_out), 32'd0);
    chk("rst.busy", 32'(bus8.busy), 32'd0);
    chk("rst.done", 32'(bus8.done), 32'd0);
    chk("rst.pass", 32'(bus8.pass), 32'd0);
    chk("rst.err", 32'(bus8.err_count), 32'd0);
    chk("rst.vec", 32'(bus8.first_err_vec), 32'd0);
    chk("rst.mask", 32'(bus8.first_err_mask), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // fault-free gate block
    run_check("t2_good", -1);
    chk("t2.pass_lit", 32'(bus8.pass), 32'd1);

    // xor stuck at 0: mismatches on vectors 10 and 01 only
    set_flips(7'h00, 7'h02, 7'h02, 7'h00);
    run_check("t3_xor0", -1);
    chk("t3.err_lit", 32'(bus8.err_count), 32'd4);
    chk("t3.vec_lit", 32'(bus8.first_err_vec), 32'b10);
    chk("t3.mask_lit", 32'(bus8.first_err_mask), 32'h02);

    // every output inverted: 8 mismatches, 2-bit counter saturates at 3
    set_flips(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    run_check("t4_inv", -1);
    chk("t4.err2_lit", 32'(bus2.err_count), 32'd3);
    chk("t4.err8_lit", 32'(bus8.err_count), 32'd8);

    // randomized fault patterns
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++)
        flip[i] = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'h00;
      run_check("rand", -1);
    end

    // start during SETTLE is ignored; then start from DONE clears results
    set_flips(7'h00, 7'h02, 7'h02, 7'h00);
    run_check("t6_glitch", 3);
    run_check("t6_restart", -1);

    // abort together with start at clock 10 of a run
    set_flips(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("t5.a_before", 32'(bus8.a_out), 32'd1);
    bus8.abort = 1'b1;
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.abort = 1'b0;
    bus8.start = 1'b0;
    chk("t5.busy", 32'(bus8.busy), 32'd0);
    chk("t5.done", 32'(bus8.done), 32'd0);
    chk("t5.a", 32'(bus8.a_out), 32'd0);
    chk("t5.b", 32'(bus8.b_out), 32'd0);
    chk("t5.err_kept", 32'(bus8.err_count), 32'd1);
    chk("t5.mask_kept", 32'(bus8.first_err_mask), 32'h7F);
    repeat (3) @(posedge clk);
    #1;
    chk("t5.idle_busy", 32'(bus8.busy), 32'd0);
    chk("t5.idle_done", 32'(bus8.done), 32'd0);
    run_check("t5_restart", -1);

    // asynchronous reset in the middle of SETTLE
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("t1.err_before", 32'(bus8.err_count), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("t1.a", 32'(bus8.a_out), 32'd0);
    chk("t1.b", 32'(bus8.b_out), 32'd0);
    chk("t1.busy", 32'(bus8.busy), 32'd0);
    chk("t1.err", 32'(bus8.err_count), 32'd0);
    chk("t1.vec", 32'(bus8.first_err_vec), 32'd0);
    chk("t1.mask", 32'(bus8.first_err_mask), 32'd0);
    chk("t1.err2", 32'(bus2.err_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t1.idle_busy", 32'(bus8.busy), 32'd0);
    chk("t1.idle_done", 32'(bus8.done), 32'd0);
    set_flips(7'h00, 7'h00, 7'h00, 7'h00);
    run_check("t1_after", -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
